// File: rtl/reg_snapshot_arbiter.sv
// Register-file read port arbiter: per-frame double-buffered snapshot of all
// core registers for the debug screen, interleaved with host debug reads.
module reg_snapshot_arbiter #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              host_gnt,
  output logic              host_valid,
  output logic [DATA_W-1:0] host_data,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              snap_valid,
  output logic              snap_done,
  output logic              overrun,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_rf_addr;
  logic              r_last_snap;
  logic              r_front;
  logic              r_snap_valid;
  logic              r_snap_done;
  logic              r_overrun;
  logic [DATA_W-1:0] r_disp_data;

  // Read pipeline tags: stage 0 is the issue visible on rf_addr this cycle,
  // stage READ_LAT lines up with the matching rf_data.
  logic [READ_LAT:0] r_tv;
  logic [READ_LAT:0] r_th;
  logic [ADDR_W-1:0] r_ta [0:READ_LAT];

  logic [DATA_W-1:0] r_bank [0:1][0:NUM_REGS-1];

  logic              w_iss_v;
  logic              w_iss_host;
  logic [ADDR_W-1:0] w_iss_addr;
  logic              w_restart;
  logic              w_swap;
  logic              w_last_cap;
  logic [1:0]        w_next_state;
  logic [ADDR_W-1:0] w_next_ptr;

  assign w_last_cap = r_tv[READ_LAT] & ~r_th[READ_LAT] & (r_ta[READ_LAT] == LAST);

  // Issue arbitration and FSM next-state; frame_start always wins the slot.
  always_comb begin
    w_iss_v      = 1'b0;
    w_iss_host   = 1'b0;
    w_iss_addr   = r_ptr;
    w_restart    = 1'b0;
    w_swap       = 1'b0;
    w_next_state = r_state;
    w_next_ptr   = r_ptr;
    if (frame_start) begin
      w_restart    = (r_state != S_IDLE);
      w_iss_v      = 1'b1;
      w_iss_addr   = '0;
      w_next_ptr   = ADDR_W'(1);
      w_next_state = (NUM_REGS == 1) ? S_DRAIN : S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (host_req && r_last_snap) begin
            w_iss_v    = 1'b1;
            w_iss_host = 1'b1;
            w_iss_addr = host_addr;
          end else begin
            w_iss_v    = 1'b1;
            w_iss_addr = r_ptr;
            w_next_ptr = r_ptr + 1'b1;
            if (r_ptr == LAST) w_next_state = S_DRAIN;
          end
        end
        default: begin
          if (host_req) begin
            w_iss_v    = 1'b1;
            w_iss_host = 1'b1;
            w_iss_addr = host_addr;
          end
          if (r_state == S_DRAIN && w_last_cap) begin
            w_swap       = 1'b1;
            w_next_state = S_IDLE;
          end
        end
      endcase
    end
  end

  // FSM state, shared read address and snapshot status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_rf_addr    <= '0;
      r_last_snap  <= 1'b0;
      r_front      <= 1'b0;
      r_snap_valid <= 1'b0;
      r_snap_done  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_ptr       <= w_next_ptr;
      r_snap_done <= w_swap;
      r_overrun   <= w_restart;
      if (w_iss_v) begin
        r_rf_addr   <= w_iss_addr;
        r_last_snap <= ~w_iss_host;
      end
      if (w_swap) begin
        r_front      <= ~r_front;
        r_snap_valid <= 1'b1;
      end
    end
  end

  // Tag shift; a restart drops in-flight snapshot reads but keeps host reads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tv <= '0;
      r_th <= '0;
    end else begin
      r_tv[0] <= w_iss_v;
      r_th[0] <= w_iss_host;
      r_ta[0] <= w_iss_addr;
      for (int unsigned i = 1; i <= READ_LAT; i++) begin
        r_tv[i] <= r_tv[i-1] & (r_th[i-1] | ~w_restart);
        r_th[i] <= r_th[i-1];
        r_ta[i] <= r_ta[i-1];
      end
    end
  end

  // Snapshot captures land in the back bank.
  always_ff @(posedge clk) begin
    if (rst && r_tv[READ_LAT] && !r_th[READ_LAT]) begin
      r_bank[~r_front][r_ta[READ_LAT]] <= rf_data;
    end
  end

  // Registered display lookup from the front bank.
  always_ff @(posedge clk) begin
    if (!rst) r_disp_data <= '0;
    else      r_disp_data <= r_bank[r_front][disp_addr];
  end

  assign rf_addr    = r_rf_addr;
  assign host_gnt   = r_tv[0] & r_th[0];
  assign host_valid = r_tv[READ_LAT] & r_th[READ_LAT];
  assign host_data  = host_valid ? rf_data : '0;
  assign disp_data  = r_disp_data;
  assign snap_valid = r_snap_valid;
  assign snap_done  = r_snap_done;
  assign overrun    = r_overrun;
  assign busy       = (r_state == S_FETCH);

endmodule

// File: tb/tb_reg_snapshot_arbiter.sv
// Bench for reg_snapshot_arbiter: two instances (READ_LAT 1 and 3) share all
// stimulus; each has its own register-file latency model and host scoreboard.
module tb_reg_snapshot_arbiter;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } hq_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        host_req;
  logic [4:0]  host_addr;
  logic [4:0]  disp_addr;
  logic [31:0] mem  [32];
  logic [31:0] snap [32];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  vec_t        tbl [6];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [31:0] host_data;
    logic [31:0] disp_data;
    logic        host_gnt, host_valid, snap_valid, snap_done, overrun, busy;
    logic [31:0] pipe [L];
    hq_t         q [$];

    reg_snapshot_arbiter #(
      .NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .READ_LAT(L)
    ) u_dut (
      .clk(clk), .rst(rst), .frame_start(frame_start),
      .rf_addr(rf_addr), .rf_data(rf_data),
      .host_req(host_req), .host_addr(host_addr),
      .host_gnt(host_gnt), .host_valid(host_valid), .host_data(host_data),
      .disp_addr(disp_addr), .disp_data(disp_data),
      .snap_valid(snap_valid), .snap_done(snap_done),
      .overrun(overrun), .busy(busy)
    );

    // Register file: data for the address on rf_addr appears L cycles later.
    always @(posedge clk) begin
      pipe[0] <= mem[rf_addr];
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign rf_data = pipe[L-1];

    always @(posedge clk) if (!rst) q.delete();

    // Host scoreboard: each grant owes one host_valid exactly L cycles later.
    always @(negedge clk) begin : mon
      hq_t e;
      if (rst) begin
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          chk("host_valid_due", 32'(host_valid), 32'd1);
          chk("host_data", host_data, e.data);
        end else begin
          chk("host_valid_spurious", 32'(host_valid), 32'd0);
        end
        if (host_gnt) begin
          chk("gnt_rf_addr", 32'(rf_addr), 32'(host_addr));
          e.due  = cyc + L;
          e.data = mem[rf_addr];
          q.push_back(e);
        end
      end
    end
  end

  function automatic logic [31:0] outs_nonzero(input int g);
    if (g == 0)
      return 32'(|{g_dut[0].rf_addr, g_dut[0].host_gnt, g_dut[0].host_valid, g_dut[0].host_data,
                   g_dut[0].disp_data, g_dut[0].snap_valid, g_dut[0].snap_done,
                   g_dut[0].overrun, g_dut[0].busy});
    return 32'(|{g_dut[1].rf_addr, g_dut[1].host_gnt, g_dut[1].host_valid, g_dut[1].host_data,
                 g_dut[1].disp_data, g_dut[1].snap_valid, g_dut[1].snap_done,
                 g_dut[1].overrun, g_dut[1].busy});
  endfunction

  // Host read handshake; lat = cycles from request sample to visible grant.
  task automatic do_host(input logic [4:0] a, output int lat);
    @(negedge clk);
    host_req  = 1'b1;
    host_addr = a;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (g_dut[0].host_gnt) begin
        lat = k;
        chk("gnt_lat3_same_cycle", 32'(g_dut[1].host_gnt), 32'd1);
        break;
      end
    end
    host_req = 1'b0;
  endtask

  // Pulse frame_start and time snap_done per instance relative to the last
  // frame_start edge; slot counts the cycle of the 32nd snapshot issue
  // (every FETCH cycle issues, a visible grant marks a host slot).
  task automatic fs_run(input int restart_at, output int n0, output int n1,
                        output int ov, output int slot, output logic [31:0] disp_mid);
    int n, snaps;
    n0 = 0; n1 = 0; ov = 0; slot = 0; disp_mid = '0; n = 0; snaps = 0;
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      n++;
      frame_start = 1'b0;
      if (k == restart_at) frame_start = 1'b1;
      if (restart_at > 0 && k == restart_at + 1) begin
        n = 1; snaps = 0; slot = 0;
      end
      if (g_dut[0].overrun) ov++;
      if (k == restart_at + 3) disp_mid = g_dut[0].disp_data;
      if (snaps < 32) begin
        if (!g_dut[0].host_gnt) snaps++;
        if (snaps == 32) slot = n;
      end
      if (g_dut[0].snap_done && n0 == 0) n0 = n;
      if (g_dut[1].snap_done && n1 == 0) n1 = n;
      if (n0 != 0 && n1 != 0) break;
    end
  endtask

  task automatic scan_all();
    @(negedge clk);
    disp_addr = 5'd0;
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      chk("scan_disp_lat1", g_dut[0].disp_data, snap[a]);
      chk("scan_disp_lat3", g_dut[1].disp_data, snap[a]);
      disp_addr = 5'(a + 1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, ov, slot, lat;
    logic [31:0] dm;

    tbl[0] = '{5'd0,  32'h0000_0000};
    tbl[1] = '{5'd5,  32'h5555_5555};
    tbl[2] = '{5'd7,  32'h7777_7777};
    tbl[3] = '{5'd15, 32'hFFFF_FFFF};
    tbl[4] = '{5'd16, 32'h1111_1110};
    tbl[5] = '{5'd31, 32'h1111_110F};

    rst = 1'b0; frame_start = 1'b0; host_req = 1'b0; host_addr = '0; disp_addr = '0;
    for (int a = 0; a < 32; a++) mem[a] = 32'(a * 32'h1111_1111);

    repeat (3) @(negedge clk);
    chk("reset_outputs_lat1", outs_nonzero(0), 32'd0);
    chk("reset_outputs_lat3", outs_nonzero(1), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("snap_valid_before_first", 32'(g_dut[0].snap_valid), 32'd0);

    // T1 / T5: plain snapshot timing, then table of display lookups.
    fs_run(0, n0, n1, ov, slot, dm);
    chk("T1_snap_done_cycle", 32'(n0), 32'd34);
    chk("T5_snap_done_cycle", 32'(n1), 32'd36);
    chk("T1_no_overrun", 32'(ov), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      disp_addr = tbl[i].addr;
      @(negedge clk);
      chk("T1_disp_lat1", g_dut[0].disp_data, tbl[i].exp);
      chk("T5_disp_lat3", g_dut[1].disp_data, tbl[i].exp);
    end
    chk("T1_snap_valid_lat1", 32'(g_dut[0].snap_valid), 32'd1);
    chk("T1_snap_valid_lat3", 32'(g_dut[1].snap_valid), 32'd1);
    chk("T1_idle_not_busy", 32'(g_dut[0].busy), 32'd0);

    // T2: host reads in IDLE from the same table.
    for (int i = 0; i < 6; i++) begin
      do_host(tbl[i].addr, lat);
      chk("T2_gnt_latency", 32'(lat), 32'd1);
      @(negedge clk);
      chk("T2_host_valid", 32'(g_dut[0].host_valid), 32'd1);
      chk("T2_host_data", g_dut[0].host_data, tbl[i].exp);
      repeat (3) @(negedge clk);
    end

    // T3: frame_start and host_req on the same edge, then a mid-FETCH request.
    fork
      fs_run(0, n0, n1, ov, slot, dm);
      do_host(5'd7, lat);
    join
    chk("T3_same_edge_gnt_lat", 32'(lat), 32'd2);
    chk("T3_same_edge_done_lat1", 32'(n0), 32'd35);
    chk("T3_same_edge_done_lat3", 32'(n1), 32'd37);
    repeat (4) @(negedge clk);
    fork
      fs_run(0, n0, n1, ov, slot, dm);
      begin
        repeat (10) @(negedge clk);
        do_host(5'd9, lat);
      end
    join
    chk("T3_fetch_gnt_wait", 32'(lat >= 1 && lat <= 2), 32'd1);
    chk("T3_fetch_done_lat1", 32'(n0), 32'd35);
    chk("T3_fetch_done_lat3", 32'(n1), 32'd37);
    repeat (4) @(negedge clk);

    // T4: restart during FETCH at ptr=10 with new register contents.
    @(negedge clk);
    disp_addr = 5'd5;
    for (int a = 0; a < 32; a++) mem[a] = 32'hC0DE_0000 | 32'(a);
    fs_run(10, n0, n1, ov, slot, dm);
    chk("T4_overrun_pulses", 32'(ov), 32'd1);
    chk("T4_old_front_kept", dm, 32'h5555_5555);
    chk("T4_done_after_restart_lat1", 32'(n0), 32'd34);
    chk("T4_done_after_restart_lat3", 32'(n1), 32'd36);
    repeat (4) @(negedge clk);
    chk("T4_new_front_lat1", g_dut[0].disp_data, 32'hC0DE_0005);
    chk("T4_new_front_lat3", g_dut[1].disp_data, 32'hC0DE_0005);

    // Randomized frames with random host traffic.
    for (int f = 0; f < 6; f++) begin
      @(negedge clk);
      for (int a = 0; a < 32; a++) begin
        mem[a]  = $urandom;
        snap[a] = mem[a];
      end
      fork
        fs_run(0, n0, n1, ov, slot, dm);
        begin
          int l2;
          repeat ($urandom_range(1, 5)) begin
            repeat ($urandom_range(0, 8)) @(negedge clk);
            do_host(5'($urandom_range(0, 31)), l2);
            chk("rand_gnt_wait", 32'(l2 >= 1 && l2 <= 2), 32'd1);
          end
        end
      join
      chk("rand_done_lat1", 32'(n0), 32'(slot + 2));
      chk("rand_done_lat3", 32'(n1), 32'(slot + 4));
      chk("rand_no_overrun", 32'(ov), 32'd0);
      repeat (4) @(negedge clk);
      scan_all();
    end

    // T6: reset mid-FETCH with a host read in flight.
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (4) @(negedge clk);
    host_req  = 1'b1;
    host_addr = 5'd3;
    lat = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (g_dut[0].host_gnt) begin
        lat = k;
        break;
      end
    end
    chk("T6_gnt_in_fetch", 32'(lat >= 1 && lat <= 2), 32'd1);
    host_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("T6_outputs_zero_lat1", outs_nonzero(0), 32'd0);
    chk("T6_outputs_zero_lat3", outs_nonzero(1), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("T6_snap_valid_cleared", 32'(g_dut[0].snap_valid | g_dut[1].snap_valid), 32'd0);
    chk("T6_idle_after_reset", 32'(g_dut[0].busy | g_dut[1].busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
